keypad_scanner: RTL and testbench

Input-side counterpart to the seven-segment display path. Scans a 4x4 active-low matrix keypad: it drives one column at a time, samples the rows, debounces a single key and emits one-cycle key events. It delivers the digit values (0-9) and operation keys (A-D) that the control FSM forwards to the display driver.

---
 rtl/keypad_scanner.sv | 191 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low matrix keypad one column at a time. It debounces a single key
// and emits one one-cycle event per accepted press. A held key never repeats.
module keypad_scanner #(
  parameter int SCAN_DIV     = 8192,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] key_col,
  input  logic [3:0] key_row,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  output logic       o_is_digit,
  output logic       o_key_held
);

  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int            DW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_meta_q, row_sync_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DW-1:0] rel_cnt_q, rel_cnt_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic          is_digit_q, is_digit_d;

  logic          sample;
  logic          rs_single;
  logic          rs_none;
  logic [1:0]    rs_idx;
  logic [3:0]    accept_code;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'd0;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clk; every decision below looks only at row_sync_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= key_row;
      row_sync_q <= row_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign sample  = (cnt_q == CNT_LAST);
  assign rs_none = (row_sync_q == 4'b1111);

  always_comb begin
    rs_single = 1'b0;
    rs_idx    = 2'd0;
    case (row_sync_q)
      4'b1110: begin rs_single = 1'b1; rs_idx = 2'd0; end
      4'b1101: begin rs_single = 1'b1; rs_idx = 2'd1; end
      4'b1011: begin rs_single = 1'b1; rs_idx = 2'd2; end
      4'b0111: begin rs_single = 1'b1; rs_idx = 2'd3; end
      default: begin rs_single = 1'b0; rs_idx = 2'd0; end
    endcase
  end

  assign accept_code = key_code(row_idx_q, col_q);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_idx_d  = row_idx_q;
    deb_cnt_d  = deb_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    valid_d    = 1'b0;
    code_d     = code_q;
    is_digit_d = is_digit_q;
    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (rs_single) begin
            row_idx_d = rs_idx;
            deb_cnt_d = DW'(1);
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (rs_single && rs_idx == row_idx_q) begin
            if (deb_cnt_q == DEB_LAST) begin
              code_d     = accept_code;
              is_digit_d = (accept_code <= 4'd9);
              valid_d    = 1'b1;
              deb_cnt_d  = '0;
              state_d    = ST_HELD;
            end else begin
              deb_cnt_d = deb_cnt_q + DW'(1);
            end
          end else begin
            deb_cnt_d = '0;
            col_d     = col_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Only an all-released keypad counts toward release; anything else restarts it.
          if (rs_none) begin
            if (rel_cnt_q == DEB_LAST) begin
              rel_cnt_d = '0;
              col_d     = col_q + 2'd1;
              state_d   = ST_SCAN;
            end else begin
              rel_cnt_d = rel_cnt_q + DW'(1);
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      col_q      <= 2'd0;
      row_idx_q  <= 2'd0;
      deb_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      valid_q    <= 1'b0;
      code_q     <= 4'd0;
      is_digit_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_idx_q  <= row_idx_d;
      deb_cnt_q  <= deb_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      is_digit_q <= is_digit_d;
    end
  end

  assign key_col     = ~(4'b0001 << col_q);
  assign o_key_valid = valid_q;
  assign o_key_code  = code_q;
  assign o_is_digit  = is_digit_q;
  assign o_key_held  = (state_q == ST_HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed slot table, hand-written corner sequences and random
// key episodes, all checked every cycle against a sample-level keypad model.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic       o_key_valid;
  logic [3:0] o_key_code;
  logic       o_is_digit;
  logic       o_key_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_col     (key_col),
    .key_row     (key_row),
    .o_key_valid (o_key_valid),
    .o_key_code  (o_key_code),
    .o_is_digit  (o_is_digit),
    .o_key_held  (o_key_held)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;
  int last_pulse_cyc = -1;

  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  // Reference model, advanced once per sample event.
  int m_col;
  int m_cand;
  int m_match;
  int m_quiet;
  int m_code;
  bit m_held;
  bit m_valid;

  typedef struct {
    logic [3:0] rows;
    logic [3:0] col;
    logic       valid;
    logic [3:0] code;
    logic       held;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_cand = -1; m_match = 0; m_quiet = 0;
    m_code = 0; m_held = 0; m_valid = 0;
  endtask

  task automatic model_sample(input logic [3:0] rs);
    int zeros;
    int r;
    zeros = 0;
    r = -1;
    for (int i = 0; i < 4; i++) begin
      if (!rs[i]) begin zeros++; r = i; end
    end
    m_valid = 0;
    if (m_held) begin
      if (rs == 4'b1111) begin
        m_quiet++;
        if (m_quiet == DEB) begin m_held = 0; m_quiet = 0; m_col = (m_col + 1) % 4; end
      end else begin
        m_quiet = 0;
      end
    end else if (m_cand >= 0) begin
      if (zeros == 1 && r == m_cand) begin
        m_match++;
        if (m_match == DEB) begin
          m_code = keymap[m_cand][m_col];
          m_valid = 1; m_held = 1; m_cand = -1; m_match = 0;
        end
      end else begin
        m_cand = -1; m_match = 0; m_col = (m_col + 1) % 4;
      end
    end else if (zeros == 1) begin
      m_cand = r; m_match = 1;
    end else begin
      m_col = (m_col + 1) % 4;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ec;
    ec = 4'b1111;
    ec[m_col] = 1'b0;
    chk("key_col", key_col, ec);
    chk("key_valid", o_key_valid, m_valid);
    chk("key_code", o_key_code, m_code);
    chk("is_digit", o_is_digit, (m_code <= 9) ? 1 : 0);
    chk("key_held", o_key_held, m_held);
  endtask

  // Rows seen by the scanner for a set of pressed keys (bit r*4+c) on the model's column.
  function automatic logic [3:0] rows_of(input logic [15:0] mask);
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (mask[r*4 + m_col]) rows[r] = 1'b0;
    end
    return rows;
  endfunction

  // One full column slot; rows are applied right after the previous sample edge.
  task automatic slot(input logic [3:0] rows);
    key_row = rows;
    for (int i = 0; i < SD; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (i == SD - 1) model_sample(rows);
      else m_valid = 0;
      if (o_key_valid) begin pulses++; last_pulse_cyc = cyc; end
      check_outputs();
    end
  endtask

  task automatic do_reset(input logic [3:0] rows);
    rst = 1'b1;
    key_row = rows;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      model_reset();
      if (o_key_valid) pulses++;
      check_outputs();
    end
    rst = 1'b0;
  endtask

  initial begin
    int det_cyc;
    int p0;
    int first_slot;
    logic [15:0] mask;
    logic [3:0] exp_cols [4];

    vecs[0]  = '{4'b1111, 4'b1101, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{4'b1101, 4'b1101, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{4'b1101, 4'b1101, 1'b0, 4'd0, 1'b0};
    vecs[3]  = '{4'b1101, 4'b1101, 1'b1, 4'd5, 1'b1};
    vecs[4]  = '{4'b1101, 4'b1101, 1'b0, 4'd5, 1'b1};
    vecs[5]  = '{4'b1111, 4'b1101, 1'b0, 4'd5, 1'b1};
    vecs[6]  = '{4'b1111, 4'b1101, 1'b0, 4'd5, 1'b1};
    vecs[7]  = '{4'b1111, 4'b1011, 1'b0, 4'd5, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0111, 1'b0, 4'd5, 1'b0};
    vecs[9]  = '{4'b0111, 4'b0111, 1'b0, 4'd5, 1'b0};
    vecs[10] = '{4'b0111, 4'b0111, 1'b0, 4'd5, 1'b0};
    vecs[11] = '{4'b1111, 4'b1110, 1'b0, 4'd5, 1'b0};
    vecs[12] = '{4'b1010, 4'b1101, 1'b0, 4'd5, 1'b0};
    vecs[13] = '{4'b1111, 4'b1011, 1'b0, 4'd5, 1'b0};
    exp_cols[0] = 4'b1101; exp_cols[1] = 4'b1011; exp_cols[2] = 4'b0111; exp_cols[3] = 4'b1110;

    rst = 1'b1;
    key_row = 4'b0000;
    model_reset();
    det_cyc = 0;

    // Reset with every row low, then plain rotation.
    do_reset(4'b0000);
    chk("rst_col", key_col, 4'b1110);
    chk("rst_valid", o_key_valid, 0);
    chk("rst_code", o_key_code, 0);
    chk("rst_held", o_key_held, 0);
    for (int i = 0; i < 4; i++) begin
      slot(4'b1111);
      chk("rotate_col", key_col, exp_cols[i]);
    end

    // Press 5, release, bounce on col3, multi on col0.
    for (int i = 0; i < 14; i++) begin
      slot(vecs[i].rows);
      if (i == 1) det_cyc = cyc;
      chk("tbl_col", key_col, vecs[i].col);
      chk("tbl_valid", o_key_valid, vecs[i].valid);
      chk("tbl_code", o_key_code, vecs[i].code);
      chk("tbl_held", o_key_held, vecs[i].held);
    end
    chk("tbl_pulses", pulses, 1);
    chk("press_latency", last_pulse_cyc - (det_cyc - 1), 9);

    // Hold '#' for 50 samples, then release.
    mask = 16'd0;
    mask[3*4 + 2] = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 50; i++) slot(rows_of(mask));
    chk("hold_pulses", pulses - p0, 1);
    chk("hold_code", o_key_code, 15);
    chk("hold_is_digit", o_is_digit, 0);
    chk("hold_held", o_key_held, 1);
    slot(4'b1111);
    chk("rel1_held", o_key_held, 1);
    slot(4'b1111);
    chk("rel2_held", o_key_held, 1);
    slot(4'b1111);
    chk("rel3_held", o_key_held, 0);
    chk("rel3_col", key_col, 4'b0111);

    // Reset after two matching samples of 'A'.
    mask = 16'd0;
    mask[0*4 + 3] = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 8 && !(m_cand >= 0 && m_match == 2); i++) slot(rows_of(mask));
    chk("midreset_armed", m_match, 2);
    do_reset(4'b1111);
    chk("midreset_col", key_col, 4'b1110);
    chk("midreset_code", o_key_code, 0);
    chk("midreset_is_digit", o_is_digit, 1);
    chk("midreset_held", o_key_held, 0);
    chk("midreset_no_pulse", pulses, p0);
    first_slot = -1;
    for (int s = 1; s <= 8; s++) begin
      slot(rows_of(mask));
      if (o_key_valid && first_slot < 0) first_slot = s;
    end
    chk("fresh_debounce_slot", first_slot, 6);
    chk("fresh_code", o_key_code, 10);
    for (int i = 0; i < 3; i++) slot(4'b1111);

    // Random key episodes: idle, single keys, key pairs, occasional reset.
    for (int e = 0; e < 60; e++) begin
      int kind;
      int dur;
      kind = $urandom_range(0, 3);
      dur  = $urandom_range(1, 10);
      mask = 16'd0;
      if (kind != 0) mask[$urandom_range(0, 15)] = 1'b1;
      if (kind == 3) mask[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 19) == 0) do_reset(4'($urandom_range(0, 15)));
      for (int i = 0; i < dur; i++) slot(rows_of(mask));
    end
    for (int i = 0; i < 4; i++) slot(4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
